// File: rtl/status_wr_arbiter.sv
// -----------------------------------------------------------------------------
// status_wr_arbiter
//
// Purpose:
//    Arbitrates between NUM_OF_INTERRUPTS status requesters and turns each
//    granted request into one qword write towards the TLP write engine.
//    Channels are served round-robin. Only one write is ever outstanding.
//    Each served channel gets a one-cycle status_ack pulse.
//    A misaligned address is acked without writing and flags err_misalign.
//    A write whose wr_done never comes is acked after TIMEOUT_CYCLES and
//    flags err_timeout.
//
// Ports:
//    s_axi_clk     in   sole clock, rising edge
//    s_axi_rst     in   synchronous active-high reset
//    status_req    in   [N]     per-channel level request, held until acked
//    status_qword  in   [64N]   per-channel write data, channel i at [64i+:64]
//    status_addr   in   [64N]   per-channel host byte address, same slicing
//    status_ack    out  [N]     one-cycle completion pulse for the served channel
//    wr_req_valid  out  1       write request to the write engine
//    wr_req_ready  in   1       write engine accepts when high with valid
//    wr_req_addr   out  64      qword-aligned host address
//    wr_req_data   out  64      qword to write
//    wr_done       in   1       pulse: accepted write has been issued
//    err_misalign  out  1       pulse in the ACK cycle of a misaligned grant
//    err_timeout   out  1       pulse in the ACK cycle of a timed-out write
//    busy          out  1       high whenever the arbiter is not in ARB
// -----------------------------------------------------------------------------
module status_wr_arbiter #(
   parameter int NUM_OF_INTERRUPTS = 1,
   parameter int TIMEOUT_CYCLES    = 1024
) (
   input  logic                           s_axi_clk,
   input  logic                           s_axi_rst,
   input  logic [NUM_OF_INTERRUPTS-1:0]    status_req,
   input  logic [64*NUM_OF_INTERRUPTS-1:0] status_qword,
   input  logic [64*NUM_OF_INTERRUPTS-1:0] status_addr,
   output logic [NUM_OF_INTERRUPTS-1:0]    status_ack,
   output logic                           wr_req_valid,
   input  logic                           wr_req_ready,
   output logic [63:0]                    wr_req_addr,
   output logic [63:0]                    wr_req_data,
   input  logic                           wr_done,
   output logic                           err_misalign,
   output logic                           err_timeout,
   output logic                           busy
);

   localparam int N     = NUM_OF_INTERRUPTS;
   // A single channel still gets a 1-bit index so every vector stays legal.
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N);
   localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(N - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ARB,
      ISSUE,
      WAIT_DONE,
      ACK,
      GAP
   } state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  last_grant_q, last_grant_d;
   logic [63:0]       addr_q, addr_d;
   logic [63:0]       data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              misalign_q, misalign_d;
   logic              timeout_q, timeout_d;

   // Round-robin pick
   logic [IDX_W:0]    rr_base;
   logic [N-1:0]      req_rot;
   logic [IDX_W-1:0]  rr_off;
   logic [IDX_W:0]    rr_sum;
   logic [IDX_W-1:0]  rr_pick;
   logic [63:0]       sel_addr;
   logic [63:0]       sel_data;

   // The request vector is rotated so that bit 0 is channel last_grant+1.
   // The lowest set bit of the rotated vector is then the next channel in
   // round-robin order, and it is mapped back to an absolute index modulo N.
   // NOTE: combinational blocks use blocking assignments and give every
   // variable a default first, so no path leaves a value unassigned (latch).
   always_comb begin
      rr_base = {1'b0, last_grant_q} + (IDX_W+1)'(1);
      if (rr_base >= N_EXT) begin
         rr_base = '0;
      end
      req_rot = N'({status_req, status_req} >> rr_base);

      rr_off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            rr_off = IDX_W'(i);
         end
      end

      rr_sum = rr_base + {1'b0, rr_off};
      if (rr_sum >= N_EXT) begin
         rr_sum = rr_sum - N_EXT;
      end
      rr_pick = rr_sum[IDX_W-1:0];

      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (rr_pick == IDX_W'(i)) begin
            sel_addr = status_addr[64*i +: 64];
            sel_data = status_qword[64*i +: 64];
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      data_d       = data_q;
      cnt_d        = '0;
      misalign_d   = misalign_q;
      timeout_d    = timeout_q;

      unique case (state_q)
         ARB: begin
            if (|status_req) begin
               // Address and data are captured here; the write uses only
               // the captured copy from now on.
               grant_d    = rr_pick;
               addr_d     = sel_addr;
               data_d     = sel_data;
               timeout_d  = 1'b0;
               misalign_d = (sel_addr[2:0] != 3'd0);
               state_d    = (sel_addr[2:0] != 3'd0) ? ACK : ISSUE;
            end
         end

         ISSUE: begin
            // wr_done is deliberately not looked at here.
            if (wr_req_ready) begin
               state_d = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            cnt_d = cnt_q + CNT_W'(1);
            // wr_done wins over a timeout landing in the same cycle.
            if (wr_done) begin
               state_d = ACK;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ACK;
               timeout_d = 1'b1;
            end
         end

         ACK: begin
            last_grant_d = grant_q;
            state_d      = GAP;
         end

         GAP: begin
            // One idle cycle lets the acked requester drop status_req.
            state_d = ARB;
         end

         default: begin
            state_d = ARB;
         end
      endcase
   end

   // State registers
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of its inputs.
   always_ff @(posedge s_axi_clk) begin
      if (s_axi_rst) begin
         state_q      <= ARB;
         grant_q      <= '0;
         last_grant_q <= LAST_CH;
         addr_q       <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         misalign_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         misalign_q   <= misalign_d;
         timeout_q    <= timeout_d;
      end
   end

   // Outputs are decoded from registered state only.
   assign wr_req_valid = (state_q == ISSUE);
   assign wr_req_addr  = addr_q;
   assign wr_req_data  = data_q;
   assign busy         = (state_q != ARB);
   assign err_misalign = (state_q == ACK) && misalign_q;
   assign err_timeout  = (state_q == ACK) && timeout_q;

   always_comb begin
      status_ack = '0;
      for (int i = 0; i < N; i++) begin
         status_ack[i] = (state_q == ACK) && (grant_q == IDX_W'(i));
      end
   end

endmodule

// File: tb/tb_status_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_status_wr_arbiter
//
// Bench for status_wr_arbiter. A four-channel instance (TIMEOUT_CYCLES=8)
// is exercised with directed and randomized transactions. A transaction
// model predicts which channel is served next and what is written. A
// one-channel instance covers the single-requester write and its latency.
// -----------------------------------------------------------------------------
module tb_status_wr_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Four-channel instance
   logic [N-1:0]    req;
   logic [64*N-1:0] qword;
   logic [64*N-1:0] addr;
   logic [N-1:0]    ack;
   logic            valid, ready, done, errm, errt, busy;
   logic [63:0]     waddr, wdata;

   status_wr_arbiter #(
      .NUM_OF_INTERRUPTS (N),
      .TIMEOUT_CYCLES    (TO)
   ) u_dut (
      .s_axi_clk    (clk),
      .s_axi_rst    (rst),
      .status_req   (req),
      .status_qword (qword),
      .status_addr  (addr),
      .status_ack   (ack),
      .wr_req_valid (valid),
      .wr_req_ready (ready),
      .wr_req_addr  (waddr),
      .wr_req_data  (wdata),
      .wr_done      (done),
      .err_misalign (errm),
      .err_timeout  (errt),
      .busy         (busy)
   );

   // Single-channel instance, default timeout
   logic        req1, ack1, valid1, ready1, done1, errm1, errt1, busy1;
   logic [63:0] qword1, addr1, waddr1, wdata1;

   status_wr_arbiter #(
      .NUM_OF_INTERRUPTS (1)
   ) u_dut_one (
      .s_axi_clk    (clk),
      .s_axi_rst    (rst),
      .status_req   (req1),
      .status_qword (qword1),
      .status_addr  (addr1),
      .status_ack   (ack1),
      .wr_req_valid (valid1),
      .wr_req_ready (ready1),
      .wr_req_addr  (waddr1),
      .wr_req_data  (wdata1),
      .wr_done      (done1),
      .err_misalign (errm1),
      .err_timeout  (errt1),
      .busy         (busy1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Transaction model: who was served last, who is asking, with what.
   int          last;
   logic [N-1:0] pend;
   logic [63:0] m_addr [N];
   logic [63:0] m_data [N];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         addr[64*i +: 64]  = m_addr[i];
         qword[64*i +: 64] = m_data[i];
      end
      req = pend;
   endtask

   // Next channel to serve: first pending one after the last served, wrapping.
   function automatic int predict();
      for (int off = 1; off <= N; off++) begin
         int ch;
         ch = (last + off) % N;
         if (pend[ch]) return ch;
      end
      return -1;
   endfunction

   function automatic logic [63:0] rand_addr(input bit mis);
      logic [63:0] a;
      a = {$urandom(), $urandom()};
      a[2:0] = mis ? 3'($urandom_range(1, 7)) : 3'd0;
      return a;
   endfunction

   // One complete transaction, entered and left in an ARB cycle.
   //   rdy_dly   : cycles wr_req_ready stays low while valid is up
   //   done_dly  : cycles after WAIT_DONE entry before wr_done; >= TO never
   //   done_hs   : also pulse wr_done in the handshake cycle (must be ignored)
   //   scramble  : change the granted channel's inputs mid-write
   //   rereq     : granted channel re-requests in its ack cycle
   task automatic serve(input int rdy_dly, input int done_dly, input bit done_hs,
                        input bit scramble, input bit rereq);
      int           ch;
      logic [63:0]  ea, ed;
      logic [N-1:0] exp_ack;
      bit           exp_to;

      ch = predict();
      if (ch < 0) begin
         n_checks++;
         $display("FAIL serve: no pending request to serve (t=%0t)", $time);
         return;
      end
      ea = m_addr[ch];
      ed = m_data[ch];
      exp_ack = '0;
      exp_ack[ch] = 1'b1;
      exp_to = 1'b0;

      tick();  // grant edge
      if (ea[2:0] != 3'd0) begin
         check("mis_valid", valid, 0);
         check("mis_ack", ack, exp_ack);
         check("mis_err", errm, 1);
         check("mis_to", errt, 0);
      end else begin
         check("valid", valid, 1);
         check("waddr", waddr, ea);
         check("wdata", wdata, ed);
         if (scramble) begin
            m_data[ch] = ~ed;
            m_addr[ch] = ea ^ 64'h100;
            drive_inputs();
         end
         ready = 1'b0;
         for (int k = 0; k < rdy_dly; k++) begin
            tick();
            check("hold_valid", valid, 1);
            check("hold_addr", waddr, ea);
            check("hold_data", wdata, ed);
         end
         ready = 1'b1;
         done  = done_hs;
         tick();  // handshake edge, now in the WAIT_DONE entry cycle
         ready = 1'b0;
         done  = 1'b0;
         check("post_hs_valid", valid, 0);
         check("post_hs_ack", ack, 0);
         check("post_hs_busy", busy, 1);

         if (done_dly < TO) begin
            for (int k = 0; k < done_dly; k++) begin
               tick();
               check("wait_ack", ack, 0);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
         end else begin
            // Counter is 0 on entry; at TO-1 the next cycle is ACK.
            for (int k = 0; k < TO - 1; k++) begin
               tick();
               check("to_wait_ack", ack, 0);
            end
            tick();
            exp_to = 1'b1;
         end
         check("ack", ack, exp_ack);
         check("ack_to", errt, exp_to);
         check("ack_mis", errm, 0);
         check("ack_valid", valid, 0);
      end

      // Requester side of the ack cycle
      last = ch;
      pend[ch] = 1'b0;
      if (rereq) begin
         pend[ch]   = 1'b1;
         m_addr[ch] = rand_addr(1'b0);
         m_data[ch] = {$urandom(), $urandom()};
      end
      drive_inputs();

      tick();  // GAP
      check("gap_ack", ack, 0);
      check("gap_busy", busy, 1);
      check("gap_valid", valid, 0);
      check("gap_err", {errm, errt}, 0);
      tick();  // ARB
      check("arb_busy", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      ready = 1'b0;
      done  = 1'b0;
      pend  = '0;
      for (int i = 0; i < N; i++) begin
         m_addr[i] = '0;
         m_data[i] = '0;
      end
      drive_inputs();
      req1 = 1'b0; ready1 = 1'b0; done1 = 1'b0; addr1 = '0; qword1 = '0;

      tick();
      tick();
      check("rst_ack", ack, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err", {errm, errt}, 0);
      check("rst_addr", waddr, 0);
      check("rst_data", wdata, 0);
      rst  = 1'b0;
      last = N - 1;

      // Single channel: write 0x05 to 0x1000. The ack lands in the fourth
      // cycle counting the cycle whose edge first samples the request.
      addr1  = 64'h1000;
      qword1 = 64'h5;
      req1   = 1'b1;
      ready1 = 1'b1;
      tick();
      check("one_valid", valid1, 1);
      check("one_addr", waddr1, 64'h1000);
      check("one_data", wdata1, 64'h5);
      tick();
      ready1 = 1'b0;
      check("one_wait_valid", valid1, 0);
      check("one_wait_ack", ack1, 0);
      done1 = 1'b1;
      tick();
      done1 = 1'b0;
      check("one_ack", ack1, 1);
      check("one_ack_busy", busy1, 1);
      req1 = 1'b0;
      tick();
      check("one_gap_ack", ack1, 0);
      check("one_gap_busy", busy1, 1);
      tick();
      check("one_idle_busy", busy1, 0);

      // All four at once: order 0,1,2,3, and 0 re-requests in its ack cycle.
      for (int i = 0; i < N; i++) begin
         m_addr[i] = 64'h2000 + 64'(i * 64);
         m_data[i] = 64'hA0 + 64'(i);
      end
      pend = '1;
      drive_inputs();
      serve(0, 0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < N; k++) serve(0, 0, 1'b0, 1'b0, 1'b0);

      // Ready held low 10 cycles, inputs changed meanwhile.
      m_addr[2] = 64'h3000;
      m_data[2] = 64'h1234_5678_9ABC_DEF0;
      pend[2] = 1'b1;
      drive_inputs();
      serve(10, 0, 1'b0, 1'b1, 1'b0);

      // wr_done on the very cycle the timeout would fire: done wins.
      m_addr[3] = 64'h4000; m_data[3] = 64'h77; pend[3] = 1'b1; drive_inputs();
      serve(0, TO - 1, 1'b0, 1'b0, 1'b0);

      // No wr_done at all: timeout, then a normal request.
      m_addr[0] = 64'h5000; m_data[0] = 64'h88; pend[0] = 1'b1; drive_inputs();
      serve(0, TO + 5, 1'b0, 1'b0, 1'b0);
      m_addr[1] = 64'h5008; m_data[1] = 64'h99; pend[1] = 1'b1; drive_inputs();
      serve(0, 1, 1'b1, 1'b0, 1'b0);

      // Misaligned address: no write, error and ack together.
      m_addr[1] = 64'h1004; m_data[1] = 64'h5; pend[1] = 1'b1; drive_inputs();
      serve(0, 0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               m_addr[i] = rand_addr($urandom_range(0, 5) == 0);
               m_data[i] = {$urandom(), $urandom()};
               pend[i]   = 1'b1;
            end
         end
         if (pend == '0) begin
            int j;
            j = int'($urandom_range(0, N - 1));
            m_addr[j] = rand_addr(1'b0);
            m_data[j] = {$urandom(), $urandom()};
            pend[j]   = 1'b1;
         end
         drive_inputs();
         serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0);
      end

      // Drain, then serve channel 0 so the last grant is not the reset value.
      for (int k = 0; k < N && pend != '0; k++) serve(0, 0, 1'b0, 1'b0, 1'b0);
      m_addr[0] = 64'h6000; m_data[0] = 64'h1; pend[0] = 1'b1; drive_inputs();
      serve(0, 0, 1'b0, 1'b0, 1'b0);

      // Reset in WAIT_DONE, then a stray wr_done.
      m_addr[1] = 64'h7000; m_data[1] = 64'h2; pend[1] = 1'b1; drive_inputs();
      ready = 1'b1;
      tick();
      check("rw_valid", valid, 1);
      tick();
      ready = 1'b0;
      check("rw_busy", busy, 1);
      rst  = 1'b1;
      pend = '0;
      drive_inputs();
      tick();
      rst  = 1'b0;
      last = N - 1;
      check("rw_ack", ack, 0);
      check("rw_valid0", valid, 0);
      check("rw_busy0", busy, 0);
      check("rw_addr0", waddr, 0);
      check("rw_data0", wdata, 0);
      check("rw_err0", {errm, errt}, 0);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rw_stray_ack", ack, 0);
      check("rw_stray_busy", busy, 0);
      tick();
      check("rw_stray_ack2", ack, 0);

      // Without the reset, channel 3 would come before channel 0 here.
      m_addr[0] = 64'h8000; m_data[0] = 64'h3;
      m_addr[3] = 64'h8008; m_data[3] = 64'h4;
      pend[0] = 1'b1;
      pend[3] = 1'b1;
      drive_inputs();
      serve(0, 0, 1'b0, 1'b0, 1'b0);
      serve(0, 0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/status_wr_arbiter.md
STATUS_WR_ARBITER -- requirements
Module: status_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_OF_INTERRUPTS, default 1, number of status requester channels (1..32).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum wait for wr_done, in cycles (>=2).
REQ-003 SHALL have port s_axi_clk  in  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port s_axi_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port status_req  in  NUM_OF_INTERRUPTS  per-channel level request; held until acked.
REQ-006 SHALL have port status_qword  in  64*NUM_OF_INTERRUPTS  per-channel write data; channel i occupies bits [64i+63:64i].
REQ-007 SHALL have port status_addr  in  64*NUM_OF_INTERRUPTS  per-channel host byte address, same slicing as status_qword.
REQ-008 SHALL have port status_ack  out  NUM_OF_INTERRUPTS  one-cycle completion pulse per channel.
REQ-009 SHALL have port wr_req_valid  out  1  write request to the TLP write engine.
REQ-010 SHALL have port wr_req_ready  in  1  write engine accepts the request when high together with valid.
REQ-011 SHALL have port wr_req_addr  out  64  qword-aligned host address.
REQ-012 SHALL have port wr_req_data  out  64  qword to write.
REQ-013 SHALL have port wr_done  in  1  one-cycle pulse; accepted write has been issued to the host.
REQ-014 SHALL have port err_misalign  out  1  one-cycle pulse; granted address had addr[2:0] != 0.
REQ-015 SHALL have port err_timeout  out  1  one-cycle pulse; wr_done was not seen within TIMEOUT_CYCLES.
REQ-016 SHALL have port busy  out  1  high in every state except ARB.

Function
REQ-017 SHALL implement FSM states ARB, ISSUE, WAIT_DONE, ACK, GAP.
REQ-018 ARB: when any status_req bit is high, SHALL grant exactly one channel, selected round-robin.
  - Search starts at last_grant+1 and wraps modulo NUM_OF_INTERRUPTS.
REQ-019 On grant, SHALL register the channel index and latch that channel's status_addr and status_qword. Later input changes SHALL NOT affect an in-flight write.
REQ-020 On grant with latched addr[2:0]==0, SHALL go to ISSUE. wr_req_valid SHALL be high on the cycle after status_req is first sampled high.
REQ-021 On grant with addr[2:0]!=0:
  - no write SHALL be issued;
  - SHALL go directly to ACK;
  - err_misalign SHALL pulse in the ACK cycle.
REQ-022 ISSUE: wr_req_valid, wr_req_addr and wr_req_data SHALL be held stable until wr_req_valid && wr_req_ready; then SHALL go to WAIT_DONE and drop valid on the next cycle.
REQ-023 WAIT_DONE: a cycle counter SHALL start at 0 on entry and increment each cycle.
  - wr_done high: go to ACK.
  - Counter reaches TIMEOUT_CYCLES-1 without wr_done: go to ACK and pulse err_timeout in the ACK cycle.
REQ-024 If wr_done and the timeout condition occur in the same cycle, wr_done SHALL win and no err_timeout pulse SHALL occur.
REQ-025 wr_done outside WAIT_DONE SHALL be ignored. This includes a wr_done in the same cycle as the ISSUE handshake.
REQ-026 ACK: status_ack[grant] SHALL be high for exactly one cycle and all other status_ack bits low. SHALL update last_grant to the granted channel, then go to GAP.
REQ-027 GAP: SHALL last one cycle with no grant, so the requester can deassert status_req, then return to ARB.
REQ-028 Minimum request-to-ack latency SHALL be 4 cycles, counted from status_req sampled high to the status_ack pulse, with wr_req_ready=1 and wr_done one cycle after the handshake.
REQ-029 A channel re-requesting in the same cycle status_ack is high SHALL be served only after every other pending channel has been served once.
REQ-030 At most one write SHALL be outstanding at any time.

Reset
REQ-031 While s_axi_rst is high, at the next edge the block SHALL set:
  - FSM to ARB;
  - last_grant to NUM_OF_INTERRUPTS-1, so channel 0 has first priority;
  - status_ack, wr_req_valid, err_misalign, err_timeout and busy to 0;
  - wr_req_addr and wr_req_data to 0;
  - timeout counter to 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no status_ack pulse. A wr_done arriving after reset SHALL be ignored.

Verification
REQ-033 N=1, status_addr=0x1000, qword=0x05, ready=1, done one cycle after handshake -> single write (0x1000, 0x05); status_ack pulse 4 cycles after req; busy falls after GAP.
REQ-034 N=4, all four req at once, ready=1, done immediate -> grants in order 0,1,2,3; channel 0 re-requests after its ack -> served after channel 3.
REQ-035 wr_req_ready held low 10 cycles -> wr_req_valid/addr/data stable all 10 cycles; channel input qword changed meanwhile -> written data is still the latched value.
REQ-036 TIMEOUT_CYCLES=8, wr_done never asserted -> err_timeout pulse and status_ack pulse in the same cycle, 8 cycles after WAIT_DONE entry; next request is served normally.
REQ-037 status_addr=0x1004 -> no wr_req_valid; err_misalign and status_ack pulse together.
REQ-038 Reset asserted during WAIT_DONE, then wr_done pulsed -> no status_ack; all outputs 0; next request is granted to channel 0 first.
